cordic_vectoring: RTL
=====================

// Module: cordic_vectoring
// PURPOSE
//  Iterative vectoring-mode CORDIC, the inverse of the rotation-mode Cordic
//  block. It takes a Cartesian pair (X,Y) and returns magnitude and phase
//  (atan2). One micro-rotation per clock, with a Start/Busy/Done handshake.
//  Sits after the DCT/rotation datapath to convert outputs back to polar form.
// PARAMETERS
//  IN_W  16  width of the signed X/Y inputs and of the Phase/Error outputs
//  ITER  16  number of micro-rotations (1..16; the atan table has 16 entries)
//  GRD    2  guard bits on the internal x/y datapath (internal width IN_W+GRD)
// PORTS
//  CLK_50M  in   1     single clock; all state changes on the rising edge
//  RST_N    in   1     asynchronous, active-low reset
//  Start    in   1     request; sampled only in IDLE
//  X        in   IN_W  signed two's-complement x; captured with Start
//  Y        in   IN_W  signed two's-complement y; captured with Start
//  Busy     out  1     high in ROT and SCALE
//  Done     out  1     one-cycle pulse; results valid from this cycle on
//  Mag      out  IN_W  unsigned magnitude, gain-compensated, saturating
//  Phase    out  IN_W  signed binary angle: 0x4000=+90 deg, 0x8000=+/-180 deg
//  Error    out  IN_W  signed residual y after the last iteration (converge check)
// BEHAVIOUR
//  Reset: state=IDLE; Busy=0, Done=0, Mag=0, Phase=0, Error=0; counter i=0.
//  States:
//   IDLE  -> ROT on Start=1.
//   ROT   -> SCALE when i==ITER-1.
//   SCALE -> IDLE unconditionally.
//  IDLE, Start=1: load pre-rotated values, set z0, clear i, and latch the
//   zero flag zf=(X==0 && Y==0).
//   - X>=0: x=X, y=Y, z=0.
//   - X<0, Y>=0: x=Y, y=-X, z=+0x4000.
//   - X<0, Y<0: x=-Y, y=X, z=-0x4000.
//   Sign-extend to IN_W+GRD before negating; -(-32768) must not overflow.
//  ROT, iteration i:
//   - y>=0: x+=y>>>i; y-=x>>>i; z+=ATAN[i].
//   - y<0: x-=y>>>i; y+=x>>>i; z-=ATAN[i].
//   - Arithmetic shifts. Both updates use the old x and y (simultaneous).
//   - z wraps modulo 2^IN_W (intended for the +/-180 deg case).
//  SCALE: Mag=sat16((x*K_INV + 2^14)>>15), with K_INV=19898 (0.60725, Q1.15).
//   Phase=z, Error=sat(y), Done=1 for this cycle only.
//   If zf: Mag=0, Phase=0, Error=0.
//  Latency: Start sampled at edge k; Done high in the cycle after edge k+ITER+1.
//   Outputs hold until the next Done. Throughput is 1 result per ITER+2 cycles.
//  Start while Busy is ignored; there is no queueing.
//   Start held high across Done re-arms on the IDLE cycle.
//  Reset mid-operation aborts immediately to the reset values; no Done follows.
//  Accuracy for ITER=16: |Phase err|<=4 LSB; |Mag err|<=2 LSB + 0.01%.
// STRUCTURE
//  cordic_pkg holds:
//   - ATAN[0..15] = {8192,4836,2555,1297,651,326,163,81,41,20,10,5,3,1,1,0}
//   - K_INV=19898 and the BAM constants Q90=16'h4000, Q180=16'h8000
//   - state encoding IDLE/ROT/SCALE
//  Sub-module cordic_atan_rom: combinational ATAN lookup indexed by i,
//   shared with the rotation-mode Cordic.
// TESTING
//  - X=16384, Y=0: Phase=0x0000+/-4, Mag=16384+/-2, Done at exactly ITER+2
//    cycles after Start.
//  - X=0, Y=16384: Phase=0x4000+/-4, Mag=16384+/-2.
//    X=0, Y=-16384: Phase=0xC000+/-4.
//  - X=10000, Y=10000: Phase=0x2000+/-4, Mag=14142+/-3.
//    X=-10000, Y=-10000: Phase=0xA000+/-4.
//  - Boundaries:
//    X=-16384, Y=0: Phase=0x8000+/-4.
//    X=-32768, Y=-32768: Mag=46341+/-5, no wrap.
//    X=Y=0: Mag=0, Phase=0, Error=0.
//  - Second Start pulsed 3 cycles into ROT: ignored; exactly one Done; the
//    result matches the first operands.
//  - RST_N low at cycle 5 of ROT: Busy, Done, Mag, Phase, Error go to 0
//    asynchronously. A new Start after release completes normally.

Source files
------------

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants, atan table and state encoding
//
// Purpose: constants shared by the vectoring CORDIC and the rotation-mode
//   CORDIC. Angles are 16-bit binary angles (BAM): 0x4000 = +90 deg and
//   0x8000 = +/-180 deg.
// Ports: none (package).
package cordic_pkg;

  localparam int          ATAN_N = 16;
  localparam logic [15:0] K_INV  = 16'd19898;  // 1/K = 0.60725 in Q1.15
  localparam logic [15:0] Q90    = 16'h4000;
  localparam logic [15:0] Q180   = 16'h8000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROT   = 2'd1,
    S_SCALE = 2'd2
  } state_t;

  // atan(2^-idx) as a 16-bit binary angle
  function automatic logic [15:0] atan_lookup(input logic [3:0] idx);
    logic [15:0] a;
    case (idx)
      4'd0:    a = 16'd8192;
      4'd1:    a = 16'd4836;
      4'd2:    a = 16'd2555;
      4'd3:    a = 16'd1297;
      4'd4:    a = 16'd651;
      4'd5:    a = 16'd326;
      4'd6:    a = 16'd163;
      4'd7:    a = 16'd81;
      4'd8:    a = 16'd41;
      4'd9:    a = 16'd20;
      4'd10:   a = 16'd10;
      4'd11:   a = 16'd5;
      4'd12:   a = 16'd3;
      4'd13:   a = 16'd1;
      4'd14:   a = 16'd1;
      default: a = 16'd0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// rtl/cordic_atan_rom.sv - combinational atan(2^-i) lookup
//
// Purpose: returns atan(2^-idx) as a binary angle OUT_W bits wide. The 16-bit
//   table is left-aligned, so any OUT_W keeps 0x4000..-style scaling (full
//   circle = 2^OUT_W).
// Ports:
//   idx   in   4       iteration index
//   angle out  OUT_W   binary angle
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic [3:0]       idx,
  output logic [OUT_W-1:0] angle
);

  logic [31:0] wide;

  always_comb begin
    wide  = {atan_lookup(idx), 16'h0000};
    angle = wide[31 -: OUT_W];
  end

endmodule

// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring-mode CORDIC (magnitude/atan2)
//
// Purpose: converts a signed Cartesian pair (X,Y) to magnitude and phase,
//   one micro-rotation per clock, with a Start/Busy/Done handshake.
// Ports:
//   CLK_50M in   1     clock, rising edge
//   RST_N   in   1     asynchronous active-low reset
//   Start   in   1     request, sampled only while idle
//   X, Y    in   IN_W  signed operands, captured with Start
//   Busy    out  1     high while rotating and scaling
//   Done    out  1     one-cycle pulse when results update
//   Mag     out  IN_W  unsigned gain-compensated magnitude (saturating)
//   Phase   out  IN_W  signed binary angle (0x4000 = +90 deg)
//   Error   out  IN_W  signed residual y (saturated) after the last iteration
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int ITER = 16,
  parameter int GRD  = 2
) (
  input  logic                   CLK_50M,
  input  logic                   RST_N,
  input  logic                   Start,
  input  logic signed [IN_W-1:0] X,
  input  logic signed [IN_W-1:0] Y,
  output logic                   Busy,
  output logic                   Done,
  output logic        [IN_W-1:0] Mag,
  output logic signed [IN_W-1:0] Phase,
  output logic signed [IN_W-1:0] Error
);

  localparam int W  = IN_W + GRD;
  localparam int PW = W + 17;           // x * K_INV product width
  localparam logic [3:0] LAST = 4'(ITER - 1);

  localparam logic signed [W-1:0]  E_MAX   = {{(GRD+1){1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic signed [W-1:0]  E_MIN   = {{(GRD+1){1'b1}}, {(IN_W-1){1'b0}}};
  localparam logic signed [PW-1:0] MAG_MAX = {{(PW-IN_W){1'b0}}, {IN_W{1'b1}}};
  localparam logic        [IN_W-1:0] Z90   = {2'b01, {(IN_W-2){1'b0}}};

  state_t                 state;
  logic [3:0]             i;
  logic signed [W-1:0]    x, y;
  logic [IN_W-1:0]        z;
  logic                   zf;

  logic signed [W-1:0]    x_in, y_in, x_sh, y_sh;
  logic [IN_W-1:0]        atan_i;
  logic signed [PW-1:0]   x_p, k_p, prod, mag_q;
  logic [IN_W-1:0]        mag_sat;
  logic signed [IN_W-1:0] err_sat;

  cordic_atan_rom #(.OUT_W(IN_W)) u_atan (
    .idx   (i),
    .angle (atan_i)
  );

  always_comb begin
    // widen before any negation so -(-2^(IN_W-1)) is representable
    x_in = {{GRD{X[IN_W-1]}}, X};
    y_in = {{GRD{Y[IN_W-1]}}, Y};
    x_sh = x >>> i;
    y_sh = y >>> i;

    // rounded Q1.15 gain compensation, clamped to the unsigned output range
    x_p   = PW'(x);
    k_p   = PW'(K_INV);
    prod  = x_p * k_p + PW'(16384);
    mag_q = prod >>> 15;
    if (mag_q < 0)
      mag_sat = '0;
    else if (mag_q > MAG_MAX)
      mag_sat = '1;
    else
      mag_sat = mag_q[IN_W-1:0];

    if (y > E_MAX)
      err_sat = E_MAX[IN_W-1:0];
    else if (y < E_MIN)
      err_sat = E_MIN[IN_W-1:0];
    else
      err_sat = y[IN_W-1:0];
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      i     <= '0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      zf    <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Mag   <= '0;
      Phase <= '0;
      Error <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            // pre-rotate into the right half-plane so the micro-rotations
            // (which cover about +/-99 deg) can converge
            if (!X[IN_W-1]) begin
              x <= x_in;
              y <= y_in;
              z <= '0;
            end else if (!Y[IN_W-1]) begin
              x <= y_in;
              y <= -x_in;
              z <= Z90;
            end else begin
              x <= -y_in;
              y <= x_in;
              z <= -Z90;
            end
            zf    <= (X == '0) && (Y == '0);
            i     <= '0;
            Busy  <= 1'b1;
            state <= S_ROT;
          end
        end

        S_ROT: begin
          if (!y[W-1]) begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + atan_i;
          end else begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - atan_i;
          end
          if (i == LAST)
            state <= S_SCALE;
          else
            i <= i + 4'd1;
        end

        S_SCALE: begin
          Mag   <= zf ? '0 : mag_sat;
          Phase <= zf ? '0 : z;
          Error <= zf ? '0 : err_sat;
          Done  <= 1'b1;
          Busy  <= 1'b0;
          i     <= '0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
